// File: rtl/ah_div_result_fifo.sv
// Result collector for the pipelined divider: buffers quotient/div-by-zero
// pairs in a small first-word-fall-through FIFO, tracks operations still in
// the divider pipeline, and counts div-by-zero results.
module ah_div_result_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_quotient,
    input  logic             in_div_by_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic             out_div_by_zero,
    output logic             overflow,
    output logic [CNT_W-1:0] dbz_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IF_W  = $clog2(2 * DEPTH) + 1;
    // Sum of occupancy and in-flight needs one bit beyond the wider operand.
    localparam int SUM_W = IF_W + 1;

    logic [WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    logic [IF_W-1:0]    inflight;
    logic               push;
    logic               pop;
    logic               full;
    logic [SUM_W-1:0]   pending;

    // Handshake decode; a full FIFO still accepts when the head leaves the same cycle.
    always_comb begin
        full            = (count == OCC_W'(DEPTH));
        out_valid       = (count != '0);
        pop             = out_valid && out_ready;
        push            = in_valid && (!full || pop);
        out_quotient    = mem[rd_ptr][WIDTH-1:0];
        out_div_by_zero = mem[rd_ptr][WIDTH];
        pending         = SUM_W'(count) + SUM_W'(inflight);
        issue_ok        = (pending < SUM_W'(DEPTH));
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_div_by_zero, in_quotient};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // In-flight tracker; a result arriving with nothing tracked leaves it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue && !in_valid) begin
            inflight <= inflight + IF_W'(1);
        end else if (in_valid && !issue && inflight != '0) begin
            inflight <= inflight - IF_W'(1);
        end
    end

    // Saturating count of div-by-zero results accepted into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_count <= '0;
        end else if (push && in_div_by_zero && dbz_count != '1) begin
            dbz_count <= dbz_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ah_div_result_fifo.sv
// Directed bench for ah_div_result_fifo with hand-computed expectations.
module tb_ah_div_result_fifo;

    localparam int WIDTH = 256;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue;
    logic             issue_ok;
    logic             in_valid;
    logic [WIDTH-1:0] in_quotient;
    logic             in_div_by_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic             out_div_by_zero;
    logic             overflow;
    logic [CNT_W-1:0] dbz_count;

    int tests  = 0;
    int failed = 0;

    ah_div_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue           (issue),
        .issue_ok        (issue_ok),
        .in_valid        (in_valid),
        .in_quotient     (in_quotient),
        .in_div_by_zero  (in_div_by_zero),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_quotient    (out_quotient),
        .out_div_by_zero (out_div_by_zero),
        .overflow        (overflow),
        .dbz_count       (dbz_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] q, input logic dbz);
        in_valid       = 1'b1;
        in_quotient    = q;
        in_div_by_zero = dbz;
        tick();
        in_valid       = 1'b0;
        in_div_by_zero = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        issue          = 1'b0;
        in_valid       = 1'b0;
        in_quotient    = '0;
        in_div_by_zero = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset then idle
        check("rst_out_valid", out_valid, 0);
        check("rst_out_quotient", out_quotient, 0);
        check("rst_out_dbz", out_div_by_zero, 0);
        check("rst_issue_ok", issue_ok, 1);
        check("rst_overflow", overflow, 0);
        check("rst_dbz_count", dbz_count, 0);

        // Three pushes, one-cycle latency, then drain in order
        push(256'h11, 1'b0);
        check("lat_out_valid", out_valid, 1);
        check("lat_head", out_quotient, 256'h11);
        // No underflow of the tracker: count 1 + inflight 0 keeps issue_ok high
        check("no_underflow_issue_ok", issue_ok, 1);
        push(256'h22, 1'b0);
        push(256'h33, 1'b0);
        check("hold_head", out_quotient, 256'h11);
        out_ready = 1'b1;
        check("pop0", out_quotient, 256'h11);
        tick();
        check("pop1", out_quotient, 256'h22);
        tick();
        check("pop2", out_quotient, 256'h33);
        tick();
        check("drained_valid", out_valid, 0);
        tick();
        check("empty_pop_valid", out_valid, 0);
        out_ready = 1'b0;

        // Overflow: fill four, then the fifth is dropped
        push(256'hA0, 1'b0);
        push(256'hA1, 1'b0);
        push(256'hA2, 1'b0);
        push(256'hA3, 1'b0);
        check("full_issue_ok", issue_ok, 0);
        check("full_no_overflow", overflow, 0);
        push(256'hAA, 1'b0);
        check("overflow_set", overflow, 1);
        out_ready = 1'b1;
        check("ovf_pop0", out_quotient, 256'hA0);
        tick();
        check("ovf_pop1", out_quotient, 256'hA1);
        tick();
        check("ovf_pop2", out_quotient, 256'hA2);
        tick();
        check("ovf_pop3", out_quotient, 256'hA3);
        tick();
        check("ovf_drained", out_valid, 0);
        check("overflow_sticky", overflow, 1);
        out_ready = 1'b0;

        // Full with simultaneous push and pop
        do_reset();
        check("rst_clears_overflow", overflow, 0);
        push(256'hB0, 1'b0);
        push(256'hB1, 1'b0);
        push(256'hB2, 1'b0);
        push(256'hB3, 1'b0);
        out_ready = 1'b1;
        push(256'hB4, 1'b0);
        out_ready = 1'b0;
        check("pp_no_overflow", overflow, 0);
        check("pp_head", out_quotient, 256'hB1);
        check("pp_still_full", issue_ok, 0);
        out_ready = 1'b1;
        tick();
        check("pp_pop1", out_quotient, 256'hB2);
        tick();
        check("pp_pop2", out_quotient, 256'hB3);
        tick();
        check("pp_pop3", out_quotient, 256'hB4);
        tick();
        check("pp_drained", out_valid, 0);
        out_ready = 1'b0;

        // In-flight tracker
        push(256'hC0, 1'b0);
        check("trk_count1", issue_ok, 1);
        issue = 1'b1;
        tick();
        check("trk_issue1", issue_ok, 1);
        tick();
        check("trk_issue2", issue_ok, 1);
        tick();
        check("trk_issue3", issue_ok, 0);
        issue = 1'b0;
        push(256'hC1, 1'b0);
        check("trk_result", issue_ok, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("trk_pop", issue_ok, 1);
        check("trk_head", out_quotient, 256'hC1);

        // Div-by-zero counting and reset with a simultaneous push
        do_reset();
        check("rst2_valid", out_valid, 0);
        check("rst2_issue_ok", issue_ok, 1);
        push(256'hD0, 1'b0);
        check("dbz_not_counted", dbz_count, 0);
        push(256'hD1, 1'b1);
        push(256'hD2, 1'b1);
        push(256'hD3, 1'b1);
        check("dbz_count3", dbz_count, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("dbz_head_flag", out_div_by_zero, 1);
        check("dbz_head_q", out_quotient, 256'hD1);
        rst            = 1'b1;
        in_valid       = 1'b1;
        in_quotient    = 256'hEE;
        in_div_by_zero = 1'b1;
        tick();
        rst            = 1'b0;
        in_valid       = 1'b0;
        in_div_by_zero = 1'b0;
        check("rst3_dbz_count", dbz_count, 0);
        check("rst3_valid", out_valid, 0);
        check("rst3_quotient", out_quotient, 0);
        check("rst3_issue_ok", issue_ok, 1);
        tick();
        check("rst3_idle_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ah_div_result_fifo.md
# ah_div_result_fifo

Downstream result collector for the 256-bit pipelined divider. Captures each quotient/div-by-zero pair on the divider's `data_valid` pulse, buffers it in a small FIFO, and presents it to the consumer over a valid/ready handshake. The divider pipeline cannot be stalled, so the block also tracks operations in flight and tells the issuing logic when another `start` is safe.

## Interface
Parameters:
- WIDTH, 256, quotient width; matches divider operand width
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 8, width of the div-by-zero event counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- issue  in  1  high for the cycle a `start` is driven into the divider
- issue_ok  out  1  combinational; high when another issue cannot overflow the FIFO
- in_valid  in  1  divider `data_valid`
- in_quotient  in  WIDTH  divider quotient
- in_div_by_zero  in  1  divider `div_by_zero`
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_quotient  out  WIDTH  head entry quotient
- out_div_by_zero  out  1  head entry div-by-zero flag
- overflow  out  1  sticky; a result was dropped
- dbz_count  out  CNT_W  saturating count of div-by-zero results pushed

## Operation
- Storage: DEPTH x (WIDTH+1) register array, write pointer `wr_ptr`, read pointer `rd_ptr`, and occupancy `count` (0..DEPTH). Pointers wrap modulo DEPTH.
- push = in_valid and (count < DEPTH or pop). pop = out_valid and out_ready.
- On push, write {in_div_by_zero, in_quotient} at wr_ptr, then advance wr_ptr. On pop, advance rd_ptr.
- count: +1 on push only; -1 on pop only; unchanged on both or neither.
- Full with in_valid, no pop: entry dropped; pointers and count unchanged; overflow set to 1 and held until rst.
- Full with in_valid and pop in the same cycle: accepted; count stays DEPTH.
- Empty with out_ready: no effect.
- Output is first-word-fall-through. out_valid = (count != 0). out_quotient and out_div_by_zero are driven combinationally from mem[rd_ptr].
- In-flight tracker `inflight`, width clog2(2*DEPTH)+1:
  - +1 on issue only; -1 on in_valid only; unchanged when both occur.
  - in_valid with inflight = 0 does not underflow; it stays 0 and the result is still pushed.
- issue_ok = (count + inflight) < DEPTH. Issue while issue_ok = 0 is a protocol violation; it is still counted.
- dbz_count: +1 per push with in_div_by_zero = 1; saturates at 2^CNT_W - 1.

## Timing
- Reset, applied for one or more cycles, clears:
  - count, pointers, inflight, dbz_count and overflow to 0
  - all memory entries to 0
- Reset output values: out_valid 0, out_quotient 0, out_div_by_zero 0, overflow 0, dbz_count 0, issue_ok 1.
- rst mid-operation discards all buffered and in-flight state on that edge. A simultaneous in_valid is ignored.
- Latency: in_valid at cycle N gives out_valid = 1 at N+1. There is no same-cycle bypass.
- Pop at cycle N presents the next entry at N+1.
- Throughput: one push and one pop per cycle, sustained.
- issue_ok reflects the count and inflight registers. An issue at cycle N lowers it from N+1.
- Overflow sets on the cycle after the dropping edge, i.e. it is visible at N+1.

## Test plan
- Reset then idle: out_valid = 0, out_quotient = 0, issue_ok = 1, overflow = 0, dbz_count = 0.
- Push quotients 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0, then raise out_ready. Required: out_valid from the first push + 1; pops return 0x11, 0x22, 0x33 in order; out_valid = 0 afterwards.
- Fill all 4 entries with out_ready = 0, then push 0xAA. Required: overflow = 1; pops return the 4 original entries; 0xAA is never output.
- Full FIFO with in_valid = 1 and out_ready = 1 in the same cycle. Required: count stays 4, no overflow, new entry appears after the 3 remaining.
- Tracker: issue on 3 cycles, no results, count = 1. Required: issue_ok = 0. One in_valid with no pop gives count = 2 and inflight = 2, so issue_ok stays 0. One pop then gives issue_ok = 1.
- Push 3 results with in_div_by_zero = 1, then assert rst. Required: dbz_count = 3 before reset; after reset, dbz_count = 0 and out_valid = 0.
